// File: rtl/bp_fe_bht_nbit_if.sv
// Bundle of the BHT training and lookup ports.
// The front end drives through "master"; the table itself uses "slave".
interface bp_fe_bht_nbit_if #(
    parameter int vaddr_width_p = 39,
    parameter int ctr_width_p   = 2,
    parameter int row_els_p     = 4,
    parameter int idx_width_p   = 9,
    parameter int ghist_width_p = 2
);
    localparam int offset_width = $clog2(row_els_p);
    localparam int row_width    = ctr_width_p * row_els_p;

    logic                     init_done_o;

    logic                     w_v_i;
    logic [idx_width_p-1:0]   w_idx_i;
    logic [offset_width-1:0]  w_offset_i;
    logic [ghist_width_p-1:0] w_ghist_i;
    logic [row_width-1:0]     w_val_i;
    logic                     w_taken_i;
    logic                     w_yumi_o;

    logic                     r_v_i;
    logic [vaddr_width_p-1:0] r_addr_i;
    logic [ghist_width_p-1:0] r_ghist_i;
    logic [row_width-1:0]     r_val_o;
    logic                     r_pred_o;
    logic [idx_width_p-1:0]   r_idx_o;
    logic [offset_width-1:0]  r_offset_o;

    modport master (
        input  init_done_o, w_yumi_o, r_val_o, r_pred_o, r_idx_o, r_offset_o,
        output w_v_i, w_idx_i, w_offset_i, w_ghist_i, w_val_i, w_taken_i,
        output r_v_i, r_addr_i, r_ghist_i
    );

    modport slave (
        output init_done_o, w_yumi_o, r_val_o, r_pred_o, r_idx_o, r_offset_o,
        input  w_v_i, w_idx_i, w_offset_i, w_ghist_i, w_val_i, w_taken_i,
        input  r_v_i, r_addr_i, r_ghist_i
    );
endinterface

// File: rtl/bp_fe_bht_nbit.sv
// N-bit saturating-counter branch history table with GSELECT/GSHARE indexing.
// A training write that collides with a same-cycle read is parked in a
// one-entry pending-write buffer and retired on a later free cycle.
// Optional macro BP_FE_BHT_BYPASS_EN: reads hitting the pending-write buffer
// return the buffered row instead of the (stale) memory row.
module bp_fe_bht_nbit #(
    parameter int vaddr_width_p = 39,
    parameter int ctr_width_p   = 2,
    parameter int row_els_p     = 4,
    parameter int idx_width_p   = 9,
    parameter int ghist_width_p = 2,
    parameter int gshare_p      = 0
) (
    input logic              clk_i,
    input logic              reset_i,
    bp_fe_bht_nbit_if.slave  bus
);
    localparam int offset_width = $clog2(row_els_p);
    localparam int row_width    = ctr_width_p * row_els_p;
    localparam int addr_width   = (gshare_p != 0) ? idx_width_p : idx_width_p + ghist_width_p;
    localparam int rows         = 1 << addr_width;
    localparam int used_bits    = 2 + idx_width_p + offset_width;

    // Weakly not-taken: just below the counter midpoint.
    localparam logic [ctr_width_p-1:0] ctr_init = {1'b0, {(ctr_width_p-1){1'b1}}};
    localparam logic [row_width-1:0]   init_row = {row_els_p{ctr_init}};

    typedef enum logic [1:0] {e_reset, e_clear, e_run} state_e;

    logic [row_width-1:0]    mem [rows];

    state_e                  state_reg;
    logic [addr_width-1:0]   clear_cnt_reg;
    logic                    init_done_reg;
    logic                    buf_v_reg;
    logic [addr_width-1:0]   buf_addr_reg;
    logic [row_width-1:0]    buf_row_reg;
    logic [row_width-1:0]    r_val_reg;
    logic [idx_width_p-1:0]  r_idx_reg;
    logic [offset_width-1:0] r_offset_reg;

    logic [idx_width_p-1:0]  r_idx;
    logic [offset_width-1:0] r_offset;
    logic [addr_width-1:0]   r_tab_addr;
    logic [addr_width-1:0]   w_tab_addr;
    logic [row_width-1:0]    w_row;
    logic [row_width-1:0]    rd_row;
    logic [row_els_p-1:0]    ctr_msbs;
    logic                    run, clearing, drain, direct, capture;
    logic                    mem_we;
    logic [addr_width-1:0]   mem_waddr;
    logic [row_width-1:0]    mem_wdata;
    logic                    unused_addr_bits;

    // PC bit 1 folds into the index so both halves of a compressed pair differ.
    assign r_idx    = bus.r_addr_i[2 +: idx_width_p] ^ idx_width_p'(bus.r_addr_i[1]);
    assign r_offset = bus.r_addr_i[2 + idx_width_p +: offset_width];

    generate
        if (vaddr_width_p > used_bits) begin : g_unused_hi
            assign unused_addr_bits = ^{bus.r_addr_i[vaddr_width_p-1:used_bits], bus.r_addr_i[0]};
        end else begin : g_unused_lo
            assign unused_addr_bits = bus.r_addr_i[0];
        end

        if (gshare_p != 0) begin : g_gshare
            assign r_tab_addr = r_idx ^ addr_width'(bus.r_ghist_i);
            assign w_tab_addr = bus.w_idx_i ^ addr_width'(bus.w_ghist_i);
        end else begin : g_gselect
            assign r_tab_addr = {bus.r_ghist_i, r_idx};
            assign w_tab_addr = {bus.w_ghist_i, bus.w_idx_i};
        end

        for (genvar gi = 0; gi < row_els_p; gi++) begin : g_ctr
            logic [ctr_width_p-1:0] old_ctr;
            logic [ctr_width_p-1:0] new_ctr;
            assign old_ctr = bus.w_val_i[gi*ctr_width_p +: ctr_width_p];
            // Saturating step on the trained counter only; others pass through.
            always_comb begin
                new_ctr = old_ctr;
                if (bus.w_offset_i == offset_width'(gi)) begin
                    if (bus.w_taken_i) begin
                        if (old_ctr != '1) new_ctr = old_ctr + 1'b1;
                    end else begin
                        if (old_ctr != '0) new_ctr = old_ctr - 1'b1;
                    end
                end
            end
            assign w_row[gi*ctr_width_p +: ctr_width_p] = new_ctr;
            assign ctr_msbs[gi] = r_val_reg[gi*ctr_width_p + ctr_width_p - 1];
        end
    endgenerate

    // Write-port arbitration: buffer drain first, then a direct write, else park.
    always_comb begin
        run       = (state_reg == e_run);
        clearing  = (state_reg == e_clear);
        drain     = run & buf_v_reg & ~(bus.r_v_i & (r_tab_addr == buf_addr_reg));
        direct    = run & bus.w_v_i & ~buf_v_reg & ~(bus.r_v_i & (r_tab_addr == w_tab_addr));
        capture   = run & bus.w_v_i & ~direct & (~buf_v_reg | drain);
        mem_we    = clearing | drain | direct;
        mem_waddr = clearing ? clear_cnt_reg : (drain ? buf_addr_reg : w_tab_addr);
        mem_wdata = clearing ? init_row : (drain ? buf_row_reg : w_row);
    end

`ifdef BP_FE_BHT_BYPASS_EN
    logic                  buf_next_v;
    logic [addr_width-1:0] buf_next_addr;
    logic [row_width-1:0]  buf_next_row;

    // Forward the row the buffer will hold after this edge when the read hits it.
    always_comb begin
        buf_next_v    = capture | (buf_v_reg & ~drain);
        buf_next_addr = capture ? w_tab_addr : buf_addr_reg;
        buf_next_row  = capture ? w_row : buf_row_reg;
        rd_row        = (buf_next_v && (buf_next_addr == r_tab_addr)) ? buf_next_row : mem[r_tab_addr];
    end
`else
    assign rd_row = mem[r_tab_addr];
`endif

    // Table storage: single write port shared by clear, drain and direct writes.
    always_ff @(posedge clk_i) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // Init sequencer, pending-write buffer and registered read outputs.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_reg     <= e_reset;
            clear_cnt_reg <= '0;
            init_done_reg <= 1'b0;
            buf_v_reg     <= 1'b0;
            buf_addr_reg  <= '0;
            buf_row_reg   <= '0;
            r_val_reg     <= '0;
            r_idx_reg     <= '0;
            r_offset_reg  <= '0;
        end else begin
            case (state_reg)
                e_reset: begin
                    state_reg     <= e_clear;
                    clear_cnt_reg <= '0;
                end
                e_clear: begin
                    if (clear_cnt_reg == '1) begin
                        state_reg     <= e_run;
                        init_done_reg <= 1'b1;
                    end else begin
                        clear_cnt_reg <= clear_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    if (capture) begin
                        buf_v_reg    <= 1'b1;
                        buf_addr_reg <= w_tab_addr;
                        buf_row_reg  <= w_row;
                    end else if (drain) begin
                        buf_v_reg    <= 1'b0;
                    end
                    if (bus.r_v_i) begin
                        r_val_reg    <= rd_row;
                        r_idx_reg    <= r_idx;
                        r_offset_reg <= r_offset;
                    end
                end
            endcase
        end
    end

    assign bus.init_done_o = init_done_reg;
    assign bus.w_yumi_o    = direct | capture;
    assign bus.r_val_o     = r_val_reg;
    assign bus.r_pred_o    = ctr_msbs[r_offset_reg];
    assign bus.r_idx_o     = r_idx_reg;
    assign bus.r_offset_o  = r_offset_reg;
endmodule

// File: tb/tb_bp_fe_bht_nbit.sv
// Self-checking bench: instance A is GSELECT with 3-bit counters and is
// checked against a row/counter reference model under random traffic;
// instance B is GSHARE with 2-bit counters and gets directed checks.
module tb_bp_fe_bht_nbit;
`ifdef BP_FE_BHT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bp_fe_bht_nbit_if #(.vaddr_width_p(39), .ctr_width_p(3), .row_els_p(4),
                        .idx_width_p(4), .ghist_width_p(2)) bus_a ();
    bp_fe_bht_nbit_if #(.vaddr_width_p(39), .ctr_width_p(2), .row_els_p(4),
                        .idx_width_p(4), .ghist_width_p(2)) bus_b ();

    bp_fe_bht_nbit #(.vaddr_width_p(39), .ctr_width_p(3), .row_els_p(4),
                     .idx_width_p(4), .ghist_width_p(2), .gshare_p(0))
        dut_a (.clk_i(clk), .reset_i(rst), .bus(bus_a));
    bp_fe_bht_nbit #(.vaddr_width_p(39), .ctr_width_p(2), .row_els_p(4),
                     .idx_width_p(4), .ghist_width_p(2), .gshare_p(1))
        dut_b (.clk_i(clk), .reset_i(rst), .bus(bus_b));

    int total = 0;
    int bad   = 0;

    // Reference model for A: committed table, pending write, last read result.
    int          m_mem [64][4];
    bit          m_bv;
    int          m_ba;
    int          m_brow [4];
    logic [11:0] last_row;
    logic        last_pred;
    int          last_idx, last_off;
    logic        yb;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int tab_a(input int idx, input int gh);
        return gh * 16 + idx;
    endfunction

    function automatic int pc_idx(input logic [38:0] pc);
        return int'(pc[5:2]) ^ int'(pc[1]);
    endfunction

    function automatic int pc_off(input logic [38:0] pc);
        return int'(pc[7:6]);
    endfunction

    function automatic logic [38:0] make_pc(input int idx, input int off);
        logic [38:0] pc;
        logic [3:0]  ix;
        logic        b1;
        ix = 4'(idx);
        b1 = 1'($urandom_range(1, 0));
        pc = 39'($urandom) << 8;
        pc[7:6] = 2'(off);
        pc[5:2] = ix ^ {3'b000, b1};
        pc[1]   = b1;
        pc[0]   = 1'($urandom_range(1, 0));
        return pc;
    endfunction

    function automatic logic [11:0] pack_a(input int r [4]);
        logic [11:0] v;
        v = '0;
        for (int k = 0; k < 4; k++) v[k*3 +: 3] = 3'(r[k]);
        return v;
    endfunction

    function automatic logic [7:0] row_b(input int c);
        logic [7:0] r;
        r = 8'h55;
        r[5:4] = 2'(c);
        return r;
    endfunction

    task automatic model_reset();
        for (int a = 0; a < 64; a++)
            for (int k = 0; k < 4; k++) m_mem[a][k] = 3;
        m_bv = 1'b0;
        m_ba = 0;
        last_row = '0; last_pred = 1'b0; last_idx = 0; last_off = 0;
    endtask

    task automatic idle_inputs();
        bus_a.r_v_i = 0; bus_a.r_addr_i = '0; bus_a.r_ghist_i = '0;
        bus_a.w_v_i = 0; bus_a.w_idx_i = '0; bus_a.w_offset_i = '0;
        bus_a.w_ghist_i = '0; bus_a.w_val_i = '0; bus_a.w_taken_i = 0;
        bus_b.r_v_i = 0; bus_b.r_addr_i = '0; bus_b.r_ghist_i = '0;
        bus_b.w_v_i = 0; bus_b.w_idx_i = '0; bus_b.w_offset_i = '0;
        bus_b.w_ghist_i = '0; bus_b.w_val_i = '0; bus_b.w_taken_i = 0;
    endtask

    // One cycle on A: drive, check handshake, advance model, check read outputs.
    task automatic step_a(input bit rv, input logic [38:0] pc, input int rgh,
                          input bit wv, input int widx, input int woff, input int wgh,
                          input logic [11:0] wval, input bit wtk, input string tag,
                          output bit y_model, output bit y_dut);
        int ra, wa;
        int nrow [4];
        int erow [4];
        bit dr, di, ca;
        @(negedge clk);
        bus_a.r_v_i = rv; bus_a.r_addr_i = pc; bus_a.r_ghist_i = 2'(rgh);
        bus_a.w_v_i = wv; bus_a.w_idx_i = 4'(widx); bus_a.w_offset_i = 2'(woff);
        bus_a.w_ghist_i = 2'(wgh); bus_a.w_val_i = wval; bus_a.w_taken_i = wtk;
        #1;
        ra = tab_a(pc_idx(pc), rgh);
        wa = tab_a(widx, wgh);
        for (int k = 0; k < 4; k++) nrow[k] = int'(wval[k*3 +: 3]);
        if (wtk) nrow[woff] = (nrow[woff] >= 7) ? 7 : nrow[woff] + 1;
        else     nrow[woff] = (nrow[woff] <= 0) ? 0 : nrow[woff] - 1;
        dr = m_bv && !(rv && ra == m_ba);
        di = wv && !m_bv && !(rv && ra == wa);
        ca = wv && !di && (!m_bv || dr);
        y_model = di || ca;
        y_dut   = bus_a.w_yumi_o;
        chk({tag, ".yumi"}, 64'(y_dut), 64'(y_model));
        erow = m_mem[ra];
        if (dr) begin m_mem[m_ba] = m_brow; m_bv = 1'b0; end
        if (di) m_mem[wa] = nrow;
        if (ca) begin m_bv = 1'b1; m_ba = wa; m_brow = nrow; end
        if (BYP && m_bv && m_ba == ra) erow = m_brow;
        if (rv) begin
            last_row  = pack_a(erow);
            last_pred = (erow[pc_off(pc)] >= 4);
            last_idx  = pc_idx(pc);
            last_off  = pc_off(pc);
        end
        @(posedge clk);
        #1;
        chk({tag, ".r_val"},    64'(bus_a.r_val_o),    64'(last_row));
        chk({tag, ".r_pred"},   64'(bus_a.r_pred_o),   64'(last_pred));
        chk({tag, ".r_idx"},    64'(bus_a.r_idx_o),    64'(last_idx));
        chk({tag, ".r_offset"}, 64'(bus_a.r_offset_o), 64'(last_off));
    endtask

    task automatic read_a(input int idx, input int gh, input int off, input string tag);
        bit ym, yd;
        step_a(1, make_pc(idx, off), gh, 0, 0, 0, 0, '0, 0, tag, ym, yd);
    endtask

    task automatic write_a(input int idx, input int gh, input int off, input bit tk, input string tag);
        bit ym, yd;
        step_a(0, make_pc(0, 0), 0, 1, idx, off, gh, pack_a(m_mem[tab_a(idx, gh)]), tk, tag, ym, yd);
    endtask

    task automatic sweep_a(input string tag);
        for (int a = 0; a < 64; a++) read_a(a % 16, a / 16, $urandom_range(3, 0), tag);
    endtask

    task automatic step_b(input bit rv, input int ridx, input int roff, input int rgh,
                          input bit wv, input int widx, input int woff, input int wgh,
                          input logic [7:0] wval, input bit wtk);
        @(negedge clk);
        bus_b.r_v_i = rv; bus_b.r_addr_i = (39'(roff) << 6) | (39'(ridx) << 2);
        bus_b.r_ghist_i = 2'(rgh);
        bus_b.w_v_i = wv; bus_b.w_idx_i = 4'(widx); bus_b.w_offset_i = 2'(woff);
        bus_b.w_ghist_i = 2'(wgh); bus_b.w_val_i = wval; bus_b.w_taken_i = wtk;
        #1;
        yb = bus_b.w_yumi_o;
        @(posedge clk);
        #1;
        bus_b.w_v_i = 0; bus_b.r_v_i = 0;
    endtask

    task automatic wait_init(output int ta, output int tb);
        ta = 0; tb = 0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(posedge clk);
            #1;
            if (ta == 0 && bus_a.init_done_o) begin
                ta = cyc;
                bus_a.w_v_i = 0; bus_a.r_v_i = 0;
            end
            if (tb == 0 && bus_b.init_done_o) tb = cyc;
            if (cyc == 10) begin
                chk("clear.yumi",  64'(bus_a.w_yumi_o), 64'(0));
                chk("clear.r_val", 64'(bus_a.r_val_o),  64'(0));
            end
            if (ta != 0 && tb != 0) break;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int  ta, tb, c, ra_idx, ra_gh;
        bit  ym, yd;
        bit  p_v;
        int  p_idx, p_off, p_gh;
        logic [11:0] p_val;
        bit  p_tk;
        logic [7:0] rb;

        idle_inputs();
        model_reset();
        #1 rst = 1'b1;
        #2;
        chk("rst.init_done", 64'(bus_a.init_done_o), 64'(0));
        chk("rst.yumi",      64'(bus_a.w_yumi_o),    64'(0));
        chk("rst.r_val",     64'(bus_a.r_val_o),     64'(0));
        chk("rst.r_pred",    64'(bus_a.r_pred_o),    64'(0));
        chk("rst.r_idx",     64'(bus_a.r_idx_o),     64'(0));
        chk("rst.r_offset",  64'(bus_a.r_offset_o),  64'(0));

        // Requests presented during init must be ignored.
        bus_a.w_v_i = 1; bus_a.r_v_i = 1; bus_a.r_addr_i = make_pc(3, 1);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        wait_init(ta, tb);
        chk("init.cycles_a", 64'(ta), 64'(65));
        chk("init.cycles_b", 64'(tb), 64'(17));
        sweep_a("init");

        // GSHARE instance: idx 5 ^ ghist 3 lands on row 6.
        step_b(0, 0, 0, 0, 1, 5, 0, 3, 8'h55, 1);
        chk("b.gshare.yumi", 64'(yb), 64'(1));
        step_b(1, 6, 0, 0, 0, 0, 0, 0, '0, 0);
        chk("b.gshare.row6",  64'(bus_b.r_val_o),  64'(8'h56));
        chk("b.gshare.pred6", 64'(bus_b.r_pred_o), 64'(1));
        step_b(1, 5, 0, 3, 0, 0, 0, 0, '0, 0);
        chk("b.gshare.alias", 64'(bus_b.r_val_o),  64'(8'h56));
        step_b(1, 5, 0, 0, 0, 0, 0, 0, '0, 0);
        chk("b.gshare.row5",  64'(bus_b.r_val_o),  64'(8'h55));
        chk("b.gshare.pred5", 64'(bus_b.r_pred_o), 64'(0));

        // 2-bit saturation on row 10, counter 2.
        c = 1;
        for (int i = 0; i < 10; i++) begin
            step_b(0, 0, 0, 0, 1, 10, 2, 0, row_b(c), 1);
            chk("b.sat.up.yumi", 64'(yb), 64'(1));
            c = (c < 3) ? c + 1 : 3;
        end
        step_b(1, 10, 2, 0, 0, 0, 0, 0, '0, 0);
        rb = bus_b.r_val_o;
        chk("b.sat.hi",     64'(rb[5:4]), 64'(3));
        chk("b.sat.nb0",    64'(rb[1:0]), 64'(1));
        chk("b.sat.nb3",    64'(rb[7:6]), 64'(1));
        chk("b.sat.hipred", 64'(bus_b.r_pred_o), 64'(1));
        for (int i = 0; i < 5; i++) begin
            step_b(0, 0, 0, 0, 1, 10, 2, 0, row_b(c), 0);
            c = (c > 0) ? c - 1 : 0;
        end
        step_b(1, 10, 2, 0, 0, 0, 0, 0, '0, 0);
        rb = bus_b.r_val_o;
        chk("b.sat.lo",     64'(rb[5:4]), 64'(0));
        chk("b.sat.nb1",    64'(rb[3:2]), 64'(1));
        chk("b.sat.lopred", 64'(bus_b.r_pred_o), 64'(0));

        // 3-bit saturation on A: row {1,3}, counter 2.
        for (int i = 0; i < 10; i++) write_a(3, 1, 2, 1, "a.sat.up");
        read_a(3, 1, 2, "a.sat.rd");
        chk("a.sat.hi",  64'(bus_a.r_val_o[8:6]), 64'(7));
        chk("a.sat.nb",  64'(bus_a.r_val_o[2:0]), 64'(3));
        for (int i = 0; i < 10; i++) write_a(3, 1, 2, 0, "a.sat.dn");
        read_a(3, 1, 2, "a.sat.rd");
        chk("a.sat.lo",  64'(bus_a.r_val_o[8:6]), 64'(0));

        // Read/write conflict on row {2,7}, counter 1.
        step_a(1, make_pc(7, 1), 2, 1, 7, 1, 2, pack_a(m_mem[tab_a(7, 2)]), 1, "a.conf", ym, yd);
        chk("a.conf.yumi", 64'(yd), 64'(1));
        read_a(7, 2, 1, "a.conf.rd1");
        chk("a.conf.first", 64'(bus_a.r_val_o[5:3]), BYP ? 64'(4) : 64'(3));
        step_a(0, make_pc(0, 0), 0, 0, 0, 0, 0, '0, 0, "a.conf.idle", ym, yd);
        read_a(7, 2, 1, "a.conf.rd2");
        chk("a.conf.after", 64'(bus_a.r_val_o[5:3]), 64'(4));

        // Back-pressure: buffer holds {2,7}; reads of it repeat while {0,9} waits.
        step_a(1, make_pc(7, 1), 2, 1, 7, 1, 2, pack_a(m_mem[tab_a(7, 2)]), 1, "a.bp.cap", ym, yd);
        for (int i = 0; i < 3; i++) begin
            step_a(1, make_pc(7, 1), 2, 1, 9, 0, 0, pack_a(m_mem[tab_a(9, 0)]), 1, "a.bp.hold", ym, yd);
            chk("a.bp.stall", 64'(yd), 64'(0));
        end
        step_a(1, make_pc(1, 0), 3, 1, 9, 0, 0, pack_a(m_mem[tab_a(9, 0)]), 1, "a.bp.go", ym, yd);
        chk("a.bp.accept", 64'(yd), 64'(1));
        step_a(0, make_pc(0, 0), 0, 0, 0, 0, 0, '0, 0, "a.bp.idle", ym, yd);
        read_a(7, 2, 1, "a.bp.rdA");
        chk("a.bp.rowA", 64'(bus_a.r_val_o[5:3]), 64'(5));
        read_a(9, 0, 0, "a.bp.rdB");
        chk("a.bp.rowB", 64'(bus_a.r_val_o[2:0]), 64'(4));

        // Random traffic with requester hold-until-yumi and biased conflicts.
        p_v = 0; p_idx = 0; p_off = 0; p_gh = 0; p_val = '0; p_tk = 0;
        for (int n = 0; n < 300; n++) begin
            int sel;
            bit rv;
            if (!p_v && $urandom_range(1, 0) == 1) begin
                p_v = 1; p_idx = $urandom_range(15, 0); p_off = $urandom_range(3, 0);
                p_gh = $urandom_range(3, 0); p_val = 12'($urandom); p_tk = 1'($urandom_range(1, 0));
            end
            rv  = ($urandom_range(3, 0) != 0);
            sel = $urandom_range(3, 0);
            if (sel == 0 && p_v)       begin ra_idx = p_idx;   ra_gh = p_gh;    end
            else if (sel == 1 && m_bv) begin ra_idx = m_ba % 16; ra_gh = m_ba / 16; end
            else begin ra_idx = $urandom_range(15, 0); ra_gh = $urandom_range(3, 0); end
            step_a(rv, make_pc(ra_idx, $urandom_range(3, 0)), ra_gh,
                   p_v, p_idx, p_off, p_gh, p_val, p_tk, "rnd", ym, yd);
            if (ym) p_v = 0;
        end
        step_a(0, make_pc(0, 0), 0, 0, 0, 0, 0, '0, 0, "rnd.idle", ym, yd);
        sweep_a("rnd.sweep");

        // Async reset with a pending write, then again mid-clear.
        step_a(1, make_pc(12, 3), 1, 1, 12, 3, 1, pack_a(m_mem[tab_a(12, 1)]), 1, "a.rst.cap", ym, yd);
        chk("a.rst.cap.yumi", 64'(yd), 64'(1));
        @(negedge clk);
        bus_a.r_v_i = 1; bus_a.r_addr_i = make_pc(12, 3); bus_a.r_ghist_i = 2'd1;
        bus_a.w_v_i = 1;
        #2 rst = 1'b1;
        #1;
        chk("arst.init_done", 64'(bus_a.init_done_o), 64'(0));
        chk("arst.yumi",      64'(bus_a.w_yumi_o),    64'(0));
        chk("arst.r_val",     64'(bus_a.r_val_o),     64'(0));
        chk("arst.r_pred",    64'(bus_a.r_pred_o),    64'(0));
        chk("arst.r_idx",     64'(bus_a.r_idx_o),     64'(0));
        chk("arst.r_offset",  64'(bus_a.r_offset_o),  64'(0));
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst.clear.init_done", 64'(bus_a.init_done_o), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        wait_init(ta, tb);
        chk("reinit.cycles_a", 64'(ta), 64'(65));
        chk("reinit.cycles_b", 64'(tb), 64'(17));
        read_a(12, 1, 3, "a.rst.rdD");
        chk("a.rst.dropped", 64'(bus_a.r_val_o[11:9]), 64'(3));
        sweep_a("reinit");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bp_fe_bht_nbit.md
# bp_fe_bht_nbit

Parametrised successor to the front-end 2-bit branch history table: rows of N-bit saturating counters, indexed by either GSELECT (history concatenated with PC bits) or GSHARE (history XOR PC bits). It sits in the FE predict stage beside the BTB. A read/write port conflict no longer drops the update: the write is held in a one-entry pending-write buffer and retired later.

## Interface
- vaddr_width_p, 39, virtual address width
- ctr_width_p, 2, counter width in bits (2..4)
- row_els_p, 4, counters per row (power of 2)
- idx_width_p, 9, row index bits taken from PC
- ghist_width_p, 2, global history bits
- gshare_p, 0, 0 = GSELECT address {ghist, idx}; 1 = GSHARE address idx ^ ghist (requires ghist_width_p ≤ idx_width_p)
- Derived: offset_width = clog2(row_els_p); row_width = ctr_width_p*row_els_p; addr_width = idx_width_p + ghist_width_p (GSELECT) or idx_width_p (GSHARE)

Ports:
- clk_i  in  1  clock
- reset_i  in  1  reset; asynchronous and active-high
- init_done_o  out  1  table cleared, normal operation
- w_v_i  in  1  training request valid
- w_idx_i  in  idx_width_p  row index returned by an earlier read
- w_offset_i  in  offset_width  counter within the row
- w_ghist_i  in  ghist_width_p  history used for that read
- w_val_i  in  row_width  row contents returned by that read
- w_taken_i  in  1  resolved direction
- w_yumi_o  out  1  training request consumed this cycle
- r_v_i  in  1  lookup valid
- r_addr_i  in  vaddr_width_p  fetch PC
- r_ghist_i  in  ghist_width_p  current global history
- r_val_o  out  row_width  row read
- r_pred_o  out  1  MSB of the selected counter
- r_idx_o  out  idx_width_p  registered index of the last read
- r_offset_o  out  offset_width  registered offset of the last read

## Operation
- Read index: r_idx = r_addr_i[2+:idx_width_p] ^ r_addr_i[1].
- Read offset: r_addr_i[2+idx_width_p+:offset_width].
- Table address: GSELECT {ghist, idx}; GSHARE idx ^ ghist, with ghist zero-extended.
- Write address: formed the same way from w_ghist_i and w_idx_i.
- FSM e_reset → e_clear → e_run:
  - e_reset lasts one cycle after reset deasserts.
  - e_clear writes every row with all counters = 2^(ctr_width_p-1)-1 (weakly not-taken), one row per cycle, address counter 0..2^addr_width-1.
  - e_clear → e_run after the last row is written. e_run holds until reset.
- Training data: w_val_i with only the counter at w_offset_i changed.
  - w_taken_i=1: +1, saturating at 2^ctr_width_p-1.
  - w_taken_i=0: −1, saturating at 0.
- Pending-write buffer: one entry holding {address, row data}.
- At most one memory write per cycle. Buffer drain has priority over a new write.
- Per-cycle rules in e_run:
  - rconf(a) = r_v_i & (r_table_addr == a).
  - drain = buf_v & ~rconf(buf_addr). The memory is written from the buffer.
  - direct = w_v_i & ~buf_v & ~rconf(w_addr). The memory is written from the incoming request.
  - capture = w_v_i & ~direct & (~buf_v | drain). The incoming request is loaded into the buffer.
  - w_yumi_o = direct | capture. The requester holds the request until w_yumi_o.
- Reads are never suppressed.
- In e_reset and e_clear: reads are ignored, w_yumi_o=0, buffer empty.

## Timing
- Reset values: init_done_o=0, w_yumi_o=0, r_val_o=0, r_pred_o=0, r_idx_o=0, r_offset_o=0, buffer empty, FSM e_reset.
- Reset asserted mid-operation: all of the above take effect immediately, the buffer is discarded, and init reruns.
- init_done_o rises exactly 2^addr_width+1 cycles after reset deasserts.
- Read latency is 1 cycle. r_val_o, r_pred_o, r_idx_o and r_offset_o hold their last value while r_v_i=0.
- A write performed in cycle t is visible to a read issued in cycle t+1.
- A write held in the buffer drains in the first cycle whose read does not target its address.
- Continuous reads to the same address stall the buffer indefinitely, with w_yumi_o=0 for further writes. This is accepted; the FE never does it.
- w_yumi_o is combinational from w_v_i, r_v_i and the read/write addresses.

## Configuration
- BP_FE_BHT_BYPASS_EN defined:
  - A read whose address equals a valid buffer address returns the buffer row in r_val_o and r_pred_o on the next cycle.
  - This also applies when the buffer is being captured in that cycle: the forwarded value is the row in the buffer after the clock edge.
- BP_FE_BHT_BYPASS_EN undefined: such reads return the memory contents, which may be stale. No forwarding mux is built.

## Test plan
- Init: ctr_width_p=3, idx_width_p=4, ghist_width_p=2 → init_done_o rises 65 cycles after reset deasserts; every read returns counters = 3 and r_pred_o=0.
- Saturation: train a single counter taken 10 times (2-bit) → it reads 3; train not-taken 5 times → it reads 0; neighbouring counters remain 1.
- Conflict:
  - Same-cycle read and write to row A → w_yumi_o=1 and the buffer is captured.
  - Without bypass, the next-cycle read shows the old row.
  - The following idle cycle drains the buffer; a later read shows the new row.
  - With BP_FE_BHT_BYPASS_EN, the first read already shows the new row.
- Back-pressure: buffer holds row A while a read of A repeats for 3 cycles and a write to B is presented → w_yumi_o=0 for those 3 cycles; on the 4th cycle A drains and B is captured or written.
- GSHARE: gshare_p=1, idx=5, ghist=3 → memory row 6 is accessed; GSELECT with the same inputs → row {3,5}.
- Async reset mid-clear and with the buffer valid → outputs are zero immediately; init reruns from row 0; the pending write is never applied.
